qe_mac_param: RTL and testbench
===============================

# qe_mac_param

Parametrised, fully pipelined successor to the team's 8-bit quadratic-equation MAC. It evaluates either a quadratic a·x² + b·x + c per input beat (mode 0) or a multi-beat dot-product accumulation Σ a·x terminated by `last_input` (mode 1). Operands and result widths are configurable, and overflow is handled by saturation or wrap. It accepts one beat per clock with a fixed 3-cycle latency and sits between the operand sequencer and the result collector in the arithmetic datapath.

## Interface
- `DATA_W`, 8: width of each unsigned operand `in_a`, `in_b`, `in_c`, `in_x`.
- `ACC_W`, 16: width of `result` and of the internal accumulator. Must be ≥ 2·DATA_W.
- `SAT`, 1: 1 = saturate to all-ones on overflow; 0 = keep the low ACC_W bits (wrap).
- `CNT_W`, 8: width of the beat counter `beat_cnt`.

- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `in_a`, `in_b`, `in_c`, `in_x` in DATA_W each: unsigned operands.
- `mode` in 1: 0 = quadratic, 1 = accumulate. Sampled per beat.
- `valid_in` in 1: the beat is accepted when this is high. There is no backpressure.
- `last_input` in 1: in mode 1, closes the accumulation run. Ignored in mode 0.
- `valid_out` out 1: one-cycle strobe; `result`, `ovf` and `beat_cnt` are valid while it is high.
- `result` out ACC_W: the computed value.
- `ovf` out 1: the true value exceeded 2^ACC_W − 1.
- `beat_cnt` out CNT_W: number of beats in the reported mode-1 run. It reads 1 for mode 0.
- `acc_busy` out 1: a mode-1 run is open (at least one beat accumulated, no `last_input` yet).

## Operation
- Unsigned arithmetic throughout. Products use full width internally, with no truncation before the final ACC_W check.
- Pipeline: S1 → S2 → S3. Each stage carries a valid bit plus the beat's `mode` and `last_input`.
  - S1: registers xx = x·x, bx = b·x, ax = a·x, a and c.
  - S2: registers axx = a·xx, s = bx + c, and ax.
  - S3: computes the output.
- Mode 0 at S3:
  - The full sum axx + s is compared against 2^ACC_W − 1.
  - `result` = the sum, or the saturated/wrapped value when it overflows.
  - `ovf` = overflow flag; `beat_cnt` = 1; `valid_out` = 1.
  - The accumulator and counter are untouched.
- Mode 1 at S3, not last:
  - acc ← acc + ax, with saturation/wrap per SAT.
  - Sticky overflow flag ← flag | overflow of this add.
  - cnt ← cnt + 1, saturating at 2^CNT_W − 1.
  - `valid_out` = 0.
- Mode 1 at S3, last:
  - Outputs `result` = acc + ax (sat/wrap), `ovf` = sticky | this overflow, `beat_cnt` = cnt + 1, `valid_out` = 1.
  - Then clears acc, cnt and the sticky flag to 0 in the same cycle.
- Beats with `valid_in` = 0 are dropped entirely, whatever the other inputs hold.
- Interleaving: a mode-0 beat arriving during an open mode-1 run produces its own output and leaves the run's state intact.
- `acc_busy` = 1 from the cycle after a non-last mode-1 beat leaves S3 until the cycle after the last beat leaves S3.

## Timing
- Latency: a beat accepted at rising edge N reaches `valid_out`/`result` after edge N+3. Throughput is 1 beat/cycle.
- Single-beat run: a mode-1 beat with `last_input` = 1 and no open run reports a·x with `beat_cnt` = 1.
- Reset: when `reset` = 1 at an edge, all stage valids, acc, cnt and the sticky flag clear.
  - Outputs after that edge: `valid_out` = 0, `result` = 0, `ovf` = 0, `beat_cnt` = 0, `acc_busy` = 0.
  - In-flight beats and open runs are discarded with no output.
  - `valid_in` is ignored while `reset` = 1.
- Outputs hold their last values between `valid_out` strobes. The first valid beat after reset may be accepted in the cycle `reset` falls.
- Saturated accumulator (SAT = 1): further adds keep it at all-ones and keep the sticky flag set.

## Test plan
- Mode 0, a=100, b=5, c=25, x=8 → three cycles later `valid_out`=1, `result`=6465, `ovf`=0, `beat_cnt`=1.
- Mode 0 with `valid_in`=0 (a=4, b=7, c=11, x=1), followed by valid a=100, b=5, c=3, x=0 → exactly one output strobe, `result`=3.
- Mode 1:
  - Stimulus: beats (100,8) valid non-last, (20,3) invalid, (1,2) valid last.
  - Response: a single strobe with `result`=802 and `beat_cnt`=2.
  - `acc_busy` is high between the two valid beats.
- Overflow, default widths, a=b=c=x=255, mode 0:
  - SAT=1 → `result`=65535, `ovf`=1.
  - SAT=0 → `result`=(16581375+65025+255) mod 65536, `ovf`=1.
- Interleave: mode-1 (3,4) non-last, then mode-0 a=1, b=0, c=0, x=2, then mode-1 (5,1) last → outputs in order 4 (`beat_cnt`=1) then 17 (`beat_cnt`=2).
- Reset mid-run: mode-1 (10,10) non-last, assert `reset` one cycle, then mode-1 (1,1) last → single output `result`=1, `beat_cnt`=1, and no output appears for the discarded beat.

Source files
------------

// File: rtl/qe_mac_param.sv
// Pipelined quadratic / dot-product MAC: a*x^2 + b*x + c per beat (mode 0) or a running sum
// of a*x closed by last_input (mode 1). Fixed 3-cycle latency, one beat per clock.
module qe_mac_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 16,
   parameter bit          SAT    = 1'b1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   input  logic [DATA_W-1:0] in_x,
   input  logic              mode,
   input  logic              valid_in,
   input  logic              last_input,
   output logic              valid_out,
   output logic [ACC_W-1:0]  result,
   output logic              ovf,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic              acc_busy
);

   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned QW    = 3 * DATA_W;
   // Wide enough for both the full quadratic sum and an ACC_W overflow bit.
   localparam int unsigned SUM_W = (QW + 1 > ACC_W + 1) ? QW + 1 : ACC_W + 1;

   // S1
   logic              s1_valid_q, s1_mode_q, s1_last_q;
   logic [PW-1:0]     xx_q, bx_q, ax1_q;
   logic [DATA_W-1:0] a_q, c_q;
   // S2
   logic              s2_valid_q, s2_mode_q, s2_last_q;
   logic [QW-1:0]     axx_q;
   logic [PW:0]       s_q;
   logic [PW-1:0]     ax2_q;
   // S3
   logic              s3_valid_q, s3_mode_q, s3_last_q;
   logic [SUM_W-1:0]  sum_q;
   logic [PW-1:0]     ax3_q;
   // Run state and registered outputs
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sticky_q, sticky_d;
   logic              busy_q, busy_d;
   logic              valid_out_q, valid_out_d;
   logic [ACC_W-1:0]  result_q, result_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_last_q  <= 1'b0;
         xx_q       <= '0;
         bx_q       <= '0;
         ax1_q      <= '0;
         a_q        <= '0;
         c_q        <= '0;
         s2_valid_q <= 1'b0;
         s2_mode_q  <= 1'b0;
         s2_last_q  <= 1'b0;
         axx_q      <= '0;
         s_q        <= '0;
         ax2_q      <= '0;
         s3_valid_q <= 1'b0;
         s3_mode_q  <= 1'b0;
         s3_last_q  <= 1'b0;
         sum_q      <= '0;
         ax3_q      <= '0;
      end else begin
         s1_valid_q <= valid_in;
         s1_mode_q  <= mode;
         s1_last_q  <= last_input;
         xx_q       <= PW'(in_x) * PW'(in_x);
         bx_q       <= PW'(in_b) * PW'(in_x);
         ax1_q      <= PW'(in_a) * PW'(in_x);
         a_q        <= in_a;
         c_q        <= in_c;
         s2_valid_q <= s1_valid_q;
         s2_mode_q  <= s1_mode_q;
         s2_last_q  <= s1_last_q;
         axx_q      <= QW'(a_q) * QW'(xx_q);
         s_q        <= (PW + 1)'(bx_q) + (PW + 1)'(c_q);
         ax2_q      <= ax1_q;
         s3_valid_q <= s2_valid_q;
         s3_mode_q  <= s2_mode_q;
         s3_last_q  <= s2_last_q;
         sum_q      <= SUM_W'(axx_q) + SUM_W'(s_q);
         ax3_q      <= ax2_q;
      end
   end

   logic [ACC_W:0]   acc_sum;
   logic             acc_ovf;
   logic [ACC_W-1:0] acc_res;
   logic             q_ovf;
   logic [ACC_W-1:0] q_res;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      acc_sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(ax3_q);
      acc_ovf = acc_sum[ACC_W];
      acc_res = (SAT && acc_ovf) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
      q_ovf   = |sum_q[SUM_W-1:ACC_W];
      q_res   = (SAT && q_ovf) ? {ACC_W{1'b1}} : sum_q[ACC_W-1:0];
      cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sticky_d    = sticky_q;
      busy_d      = busy_q;
      valid_out_d = 1'b0;
      result_d    = result_q;
      ovf_d       = ovf_q;
      beat_cnt_d  = beat_cnt_q;

      if (s3_valid_q) begin
         if (!s3_mode_q) begin
            // Quadratic beats report immediately and leave any open run untouched.
            valid_out_d = 1'b1;
            result_d    = q_res;
            ovf_d       = q_ovf;
            beat_cnt_d  = CNT_W'(1);
         end else if (!s3_last_q) begin
            acc_d    = acc_res;
            sticky_d = sticky_q | acc_ovf;
            cnt_d    = cnt_inc;
            busy_d   = 1'b1;
         end else begin
            valid_out_d = 1'b1;
            result_d    = acc_res;
            ovf_d       = sticky_q | acc_ovf;
            beat_cnt_d  = cnt_inc;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            busy_d      = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         sticky_q    <= 1'b0;
         busy_q      <= 1'b0;
         valid_out_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         busy_q      <= busy_d;
         valid_out_q <= valid_out_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign valid_out = valid_out_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign beat_cnt  = beat_cnt_q;
   assign acc_busy  = busy_q;

endmodule

// File: tb/tb_qe_mac_param.sv
// Directed bench for qe_mac_param: a saturating and a wrapping instance share one stimulus
// stream; strobes are captured into queues and compared against hand-computed values.
module tb_qe_mac_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_a, in_b, in_c, in_x;
   logic       mode, valid_in, last_input;

   logic        vo_s, ovf_s, busy_s;
   logic [15:0] res_s;
   logic [7:0]  cnt_s;
   logic        vo_w, ovf_w, busy_w;
   logic [15:0] res_w;
   logic [7:0]  cnt_w;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] q_res_s[$], q_res_w[$];
   logic        q_ovf_s[$], q_ovf_w[$], q_vo_w[$];
   logic [7:0]  q_cnt_s[$], q_cnt_w[$];

   always #5 clk = ~clk;

   qe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT(1'b1), .CNT_W(8)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_c       (in_c),
      .in_x       (in_x),
      .mode       (mode),
      .valid_in   (valid_in),
      .last_input (last_input),
      .valid_out  (vo_s),
      .result     (res_s),
      .ovf        (ovf_s),
      .beat_cnt   (cnt_s),
      .acc_busy   (busy_s)
   );

   qe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT(1'b0), .CNT_W(8)) u_wrap (
      .clk        (clk),
      .reset      (reset),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_c       (in_c),
      .in_x       (in_x),
      .mode       (mode),
      .valid_in   (valid_in),
      .last_input (last_input),
      .valid_out  (vo_w),
      .result     (res_w),
      .ovf        (ovf_w),
      .beat_cnt   (cnt_w),
      .acc_busy   (busy_w)
   );

   always @(negedge clk) begin
      if (vo_s) begin
         q_res_s.push_back(res_s);
         q_ovf_s.push_back(ovf_s);
         q_cnt_s.push_back(cnt_s);
         q_res_w.push_back(res_w);
         q_ovf_w.push_back(ovf_w);
         q_cnt_w.push_back(cnt_w);
         q_vo_w.push_back(vo_w);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic m, input logic l, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
      @(negedge clk);
      valid_in   = v;
      mode       = m;
      last_input = l;
      in_a       = a;
      in_b       = b;
      in_c       = c;
      in_x       = x;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic flush();
      q_res_s.delete();
      q_ovf_s.delete();
      q_cnt_s.delete();
      q_res_w.delete();
      q_ovf_w.delete();
      q_cnt_w.delete();
      q_vo_w.delete();
   endtask

   task automatic expect_out(input string tag, input logic [15:0] er_s, input logic eo_s,
                             input logic [15:0] er_w, input logic eo_w, input logic [7:0] ec);
      if (q_res_s.size() == 0) begin
         check_eq({tag, " strobe present"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, " result sat"}, 32'(q_res_s.pop_front()), 32'(er_s));
         check_eq({tag, " ovf sat"}, 32'(q_ovf_s.pop_front()), 32'(eo_s));
         check_eq({tag, " beat_cnt sat"}, 32'(q_cnt_s.pop_front()), 32'(ec));
         check_eq({tag, " result wrap"}, 32'(q_res_w.pop_front()), 32'(er_w));
         check_eq({tag, " ovf wrap"}, 32'(q_ovf_w.pop_front()), 32'(eo_w));
         check_eq({tag, " beat_cnt wrap"}, 32'(q_cnt_w.pop_front()), 32'(ec));
         check_eq({tag, " valid_out wrap"}, 32'(q_vo_w.pop_front()), 32'd1);
      end
   endtask

   initial begin
      // Reset with a valid beat held on the inputs: it must be ignored.
      reset = 1'b1;
      valid_in = 1'b1; mode = 1'b0; last_input = 1'b0;
      in_a = 8'd9; in_b = 8'd9; in_c = 8'd9; in_x = 8'd9;
      repeat (3) @(negedge clk);
      check_eq("reset valid_out", 32'(vo_s), 32'd0);
      check_eq("reset result", 32'(res_s), 32'd0);
      check_eq("reset ovf", 32'(ovf_s), 32'd0);
      check_eq("reset beat_cnt", 32'(cnt_s), 32'd0);
      check_eq("reset acc_busy", 32'(busy_s), 32'd0);
      reset = 1'b0;
      valid_in = 1'b0;
      idle(6);
      check_eq("reset beats dropped", 32'(q_res_s.size()), 32'd0);
      flush();

      // Quadratic with exact latency: 100*64 + 5*8 + 25 = 6465.
      drive(1'b1, 1'b0, 1'b0, 8'd100, 8'd5, 8'd25, 8'd8);
      @(negedge clk);
      valid_in = 1'b0;
      check_eq("lat edge N", 32'(vo_s), 32'd0);
      @(negedge clk);
      check_eq("lat edge N+1", 32'(vo_s), 32'd0);
      @(negedge clk);
      check_eq("lat edge N+2", 32'(vo_s), 32'd0);
      @(negedge clk);
      check_eq("lat edge N+3", 32'(vo_s), 32'd1);
      check_eq("quad result", 32'(res_s), 32'd6465);
      check_eq("quad ovf", 32'(ovf_s), 32'd0);
      check_eq("quad beat_cnt", 32'(cnt_s), 32'd1);
      @(negedge clk);
      check_eq("strobe one cycle", 32'(vo_s), 32'd0);
      check_eq("result held", 32'(res_s), 32'd6465);
      idle(3);
      flush();

      // Invalid beat dropped, then 0 + 0 + 3.
      drive(1'b0, 1'b0, 1'b0, 8'd4, 8'd7, 8'd11, 8'd1);
      drive(1'b1, 1'b0, 1'b0, 8'd100, 8'd5, 8'd3, 8'd0);
      idle(6);
      check_eq("invalid strobes", 32'(q_res_s.size()), 32'd1);
      expect_out("invalid", 16'd3, 1'b0, 16'd3, 1'b0, 8'd1);
      flush();

      // Accumulate 100*8 + 1*2 with an invalid beat in between.
      check_eq("busy idle", 32'(busy_s), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'd100, 8'd0, 8'd0, 8'd8);
      drive(1'b0, 1'b1, 1'b0, 8'd20, 8'd0, 8'd0, 8'd3);
      drive(1'b1, 1'b1, 1'b1, 8'd1, 8'd0, 8'd0, 8'd2);
      idle(3);
      check_eq("busy open run", 32'(busy_s), 32'd1);
      check_eq("busy open run wrap", 32'(busy_w), 32'd1);
      idle(4);
      check_eq("busy closed", 32'(busy_s), 32'd0);
      check_eq("acc strobes", 32'(q_res_s.size()), 32'd1);
      expect_out("acc", 16'd802, 1'b0, 16'd802, 1'b0, 8'd2);
      flush();

      // Quadratic overflow: 255^3 + 255^2 + 255 = 16646655, mod 65536 = 511.
      drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
      idle(6);
      expect_out("quad ovf", 16'd65535, 1'b1, 16'd511, 1'b1, 8'd1);
      flush();

      // Accumulator overflow: 3 x 65025 -> sat 65535, wrap 195075 mod 65536 = 64003.
      drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd0, 8'd0, 8'd255);
      drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd0, 8'd0, 8'd255);
      drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 8'd255);
      idle(6);
      expect_out("acc ovf", 16'd65535, 1'b1, 16'd64003, 1'b1, 8'd3);
      flush();

      // Single-beat run and interleaved quadratic inside an open run.
      drive(1'b1, 1'b1, 1'b1, 8'd7, 8'd0, 8'd0, 8'd6);
      idle(6);
      expect_out("single beat", 16'd42, 1'b0, 16'd42, 1'b0, 8'd1);
      flush();
      drive(1'b1, 1'b1, 1'b0, 8'd3, 8'd0, 8'd0, 8'd4);
      drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd2);
      drive(1'b1, 1'b1, 1'b1, 8'd5, 8'd0, 8'd0, 8'd1);
      idle(6);
      check_eq("interleave strobes", 32'(q_res_s.size()), 32'd2);
      expect_out("interleave quad", 16'd4, 1'b0, 16'd4, 1'b0, 8'd1);
      expect_out("interleave acc", 16'd17, 1'b0, 16'd17, 1'b0, 8'd2);
      flush();

      // Reset mid-run discards the open beat; next run starts clean.
      drive(1'b1, 1'b1, 1'b0, 8'd10, 8'd0, 8'd0, 8'd10);
      @(negedge clk);
      valid_in = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midrun reset result", 32'(res_s), 32'd0);
      check_eq("midrun reset beat_cnt", 32'(cnt_s), 32'd0);
      check_eq("midrun reset busy", 32'(busy_s), 32'd0);
      valid_in = 1'b1; mode = 1'b1; last_input = 1'b1;
      in_a = 8'd1; in_b = 8'd0; in_c = 8'd0; in_x = 8'd1;
      idle(7);
      check_eq("midrun strobes", 32'(q_res_s.size()), 32'd1);
      expect_out("midrun", 16'd1, 1'b0, 16'd1, 1'b0, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
